br_pred: RTL and testbench

Bimodal branch predictor for the fetch stage of the RV64 core. It looks up a table of 2-bit saturating counters using the fetch PC and supplies the prediction bit and the predicted next PC. The prediction bit travels down the pipeline to the execute-stage branch resolver. The resolver's outcome comes back into this block, and the table is updated through a one-entry pending-write register with bypass. The block also keeps saturating counters of branches and mispredictions for performance monitoring.

---
 rtl/br_pred_pkg.sv | 28 ++
 rtl/br_bht.sv | 60 ++++++
 rtl/br_pred.sv | 75 +++++++
 tb/tb_br_pred.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/br_pred_pkg.sv
// Shared core definitions: branch opcode, 2-bit counter encodings and
// helpers reused by the fetch predictor and the execute-stage resolver.
package br_pred_pkg;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_SNT = 2'b00;
   localparam ctr_t CTR_WNT = 2'b01;
   localparam ctr_t CTR_WT  = 2'b10;
   localparam ctr_t CTR_ST  = 2'b11;

   function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
      ctr_t res;
      if (taken) begin
         res = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
      end else begin
         res = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
      end
      return res;
   endfunction

   function automatic logic [63:0] b_imm(input logic [31:0] ir);
      return {{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/br_bht.sv
// Branch history table: 2-bit counter array, lookup and update read ports,
// and a one-entry pending write register whose value bypasses the array.
module br_bht
   import br_pred_pkg::*;
#(
   parameter int unsigned IDX_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] lk_idx_i,
   output ctr_t             lk_ctr_o,
   input  logic             up_en_i,
   input  logic [IDX_W-1:0] up_idx_i,
   input  logic             up_taken_i,
   output ctr_t             up_ctr_o
);

   localparam int unsigned Entries = 2 ** IDX_W;

   ctr_t             ctr_q [Entries];
   logic             pend_vld_q;
   logic [IDX_W-1:0] pend_idx_q;
   ctr_t             pend_ctr_q;

   always_comb begin
      lk_ctr_o = ctr_q[lk_idx_i];
      if (pend_vld_q && (pend_idx_q == lk_idx_i)) begin
         lk_ctr_o = pend_ctr_q;
      end
   end

   always_comb begin
      up_ctr_o = ctr_q[up_idx_i];
      if (pend_vld_q && (pend_idx_q == up_idx_i)) begin
         up_ctr_o = pend_ctr_q;
      end
   end

   // The update reads through the bypass, so back-to-back updates chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(Entries); i++) begin
            ctr_q[i] <= CTR_WNT;
         end
         pend_vld_q <= 1'b0;
         pend_idx_q <= '0;
         pend_ctr_q <= CTR_WNT;
      end else begin
         if (pend_vld_q) begin
            ctr_q[pend_idx_q] <= pend_ctr_q;
         end
         pend_vld_q <= up_en_i;
         if (up_en_i) begin
            pend_idx_q <= up_idx_i;
            pend_ctr_q <= ctr_next(up_ctr_o, up_taken_i);
         end
      end
   end

endmodule

// File: rtl/br_pred.sv
// Bimodal branch predictor for fetch: prediction bit, predicted next PC
// and saturating branch / misprediction statistics.
module br_pred
   import br_pred_pkg::*;
#(
   parameter int unsigned IDX_W = 6,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [63:0]      if_pc,
   input  logic [31:0]      if_ir,
   output logic             pr_taken,
   output logic [63:0]      pr_addr,
   input  logic             ex_br,
   input  logic [63:0]      ex_pc,
   input  logic             ex_taken,
   input  logic             ex_miss,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   ctr_t             lk_ctr;
   ctr_t             up_ctr;
   logic             is_br;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
   logic             unused_bits;

   br_bht #(
      .IDX_W (IDX_W)
   ) u_bht (
      .clk        (clk),
      .rst        (rst),
      .lk_idx_i   (if_pc[IDX_W+1:2]),
      .lk_ctr_o   (lk_ctr),
      .up_en_i    (ex_br),
      .up_idx_i   (ex_pc[IDX_W+1:2]),
      .up_taken_i (ex_taken),
      .up_ctr_o   (up_ctr)
   );

   assign unused_bits = ^{up_ctr, if_ir[24:12], ex_pc[63:IDX_W+2], ex_pc[1:0]};

   always_comb begin
      is_br    = (if_ir[6:0] == OP_BRANCH);
      pr_taken = is_br & lk_ctr[1];
      pr_addr  = if_pc + (pr_taken ? b_imm(if_ir) : 64'd4);
   end

   always_comb begin
      br_cnt_d   = br_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (ex_br && (br_cnt_q != '1)) begin
         br_cnt_d = br_cnt_q + CNT_W'(1);
      end
      if (ex_br && ex_miss && (miss_cnt_q != '1)) begin
         miss_cnt_d = miss_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_cnt_q   <= '0;
         miss_cnt_q <= '0;
      end else begin
         br_cnt_q   <= br_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign br_cnt   = br_cnt_q;
   assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_br_pred.sv
// Self-checking bench for br_pred: directed vector table, hand sequences for
// bypass/reset/saturation, and random traffic against an architectural model.
module tb_br_pred;

   localparam int CNT_W = 8;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [63:0]      if_pc = '0;
   logic [31:0]      if_ir = '0;
   logic             pr_taken;
   logic [63:0]      pr_addr;
   logic             ex_br = 1'b0;
   logic [63:0]      ex_pc = '0;
   logic             ex_taken = 1'b0;
   logic             ex_miss = 1'b0;
   logic [CNT_W-1:0] br_cnt;
   logic [CNT_W-1:0] miss_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   br_pred #(
      .IDX_W (6),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .if_pc    (if_pc),
      .if_ir    (if_ir),
      .pr_taken (pr_taken),
      .pr_addr  (pr_addr),
      .ex_br    (ex_br),
      .ex_pc    (ex_pc),
      .ex_taken (ex_taken),
      .ex_miss  (ex_miss),
      .br_cnt   (br_cnt),
      .miss_cnt (miss_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [63:0] pc;
      logic [31:0] ir;
      logic        br;
      logic [63:0] epc;
      logic        tk;
      logic        miss;
      logic        e_tk;
      logic [63:0] e_addr;
      int          e_br;
      int          e_miss;
   } vec_t;

   vec_t vecs[$];

   // Architectural view: counter per index, updates visible from the next cycle.
   int mctr [64];
   int mbr, mmiss;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic [63:0] pc, input logic [31:0] ir,
                               input logic br, input logic [63:0] epc, input logic tk,
                               input logic miss, input logic etk, input logic [63:0] eaddr,
                               input int ebr, input int emiss);
      vec_t v;
      v.rst = r; v.pc = pc; v.ir = ir; v.br = br; v.epc = epc; v.tk = tk; v.miss = miss;
      v.e_tk = etk; v.e_addr = eaddr; v.e_br = ebr; v.e_miss = emiss;
      return v;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 64; i++) mctr[i] = 1;
      mbr = 0;
      mmiss = 0;
   endfunction

   function automatic int pc_idx(input logic [63:0] pc);
      return int'((pc >> 2) % 64);
   endfunction

   function automatic logic [63:0] model_addr(input logic [63:0] pc, input logic [31:0] ir,
                                              input logic tk);
      longint imm;
      if (!tk) return pc + 64'd4;
      imm = ir[31] ? -64'sd4096 : 64'sd0;
      imm += longint'(ir[7]) * 2048 + longint'(ir[30:25]) * 32 + longint'(ir[11:8]) * 2;
      return pc + 64'(imm);
   endfunction

   task automatic pulse_rst();
      rst = 1'b1;
      #1;
      rst = 1'b0;
   endtask

   // Called at posedge+1; returns at next posedge+1.
   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic exp_tk;
      logic [63:0] epc_al;

      // Directed table
      //          rst  pc         ir            br epc        tk ms etk eaddr     br m
      vecs.push_back(mk(1, 64'h1000, 32'h63,  0, 64'h0,    0, 0, 0, 64'h1004, 0, 0));
      vecs.push_back(mk(0, 64'h1000, 32'h863, 1, 64'h1000, 1, 1, 0, 64'h1004, 0, 0));
      vecs.push_back(mk(0, 64'h1000, 32'h863, 0, 64'h0,    0, 0, 1, 64'h1010, 1, 1));
      vecs.push_back(mk(0, 64'h1000, 32'h13,  0, 64'h0,    0, 0, 0, 64'h1004, 1, 1));
      vecs.push_back(mk(1, 64'h2000, 32'h863, 1, 64'h2000, 1, 0, 0, 64'h2004, 0, 0));
      vecs.push_back(mk(0, 64'h2000, 32'h863, 1, 64'h2000, 1, 0, 1, 64'h2010, 1, 0));
      vecs.push_back(mk(0, 64'h2000, 32'h863, 1, 64'h2000, 1, 0, 1, 64'h2010, 2, 0));
      vecs.push_back(mk(0, 64'h2000, 32'h863, 1, 64'h2000, 1, 0, 1, 64'h2010, 3, 0));
      vecs.push_back(mk(0, 64'h2000, 32'h863, 1, 64'h2000, 0, 0, 1, 64'h2010, 4, 0));
      vecs.push_back(mk(0, 64'h2000, 32'h863, 1, 64'h2000, 0, 0, 1, 64'h2010, 5, 0));
      vecs.push_back(mk(0, 64'h2000, 32'h863, 1, 64'h2000, 0, 0, 0, 64'h2004, 6, 0));
      vecs.push_back(mk(0, 64'h2000, 32'h863, 0, 64'h0,    0, 0, 0, 64'h2004, 7, 0));
      vecs.push_back(mk(1, 64'h3100, 32'h863, 1, 64'h3000, 1, 1, 0, 64'h3104, 0, 0));
      vecs.push_back(mk(0, 64'h3100, 32'h863, 1, 64'h3100, 0, 1, 1, 64'h3110, 1, 1));
      vecs.push_back(mk(0, 64'h3100, 32'h863, 1, 64'h3000, 1, 1, 0, 64'h3104, 2, 2));
      vecs.push_back(mk(0, 64'h3100, 32'h863, 1, 64'h3100, 0, 1, 1, 64'h3110, 3, 3));
      vecs.push_back(mk(0, 64'h3100, 32'h863, 0, 64'h0,    0, 0, 0, 64'h3104, 4, 4));
      vecs.push_back(mk(1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h1463, 1, 64'hFFFF_FFFF_FFFF_FFFC,
                        1, 0, 0, 64'h0, 0, 0));
      vecs.push_back(mk(0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h1463, 0, 64'h0,
                        0, 0, 1, 64'h4, 1, 0));

      #12;
      rst = 1'b0;
      next_edge();

      foreach (vecs[i]) begin
         if (vecs[i].rst) pulse_rst();
         if_pc = vecs[i].pc; if_ir = vecs[i].ir;
         ex_br = vecs[i].br; ex_pc = vecs[i].epc;
         ex_taken = vecs[i].tk; ex_miss = vecs[i].miss;
         #2;
         chk($sformatf("vec%0d pr_taken", i), 64'(pr_taken), 64'(vecs[i].e_tk));
         chk($sformatf("vec%0d pr_addr", i), pr_addr, vecs[i].e_addr);
         chk($sformatf("vec%0d br_cnt", i), 64'(br_cnt), 64'(vecs[i].e_br));
         chk($sformatf("vec%0d miss_cnt", i), 64'(miss_cnt), 64'(vecs[i].e_miss));
         next_edge();
      end

      // Same-cycle lookup/update, bypass, then reset in the bypass cycle
      pulse_rst();
      if_pc = 64'h4000; if_ir = 32'h863;
      ex_br = 1'b1; ex_pc = 64'h4000; ex_taken = 1'b1; ex_miss = 1'b0;
      #2;
      chk("same_cycle pr_taken", 64'(pr_taken), 64'd0);
      chk("same_cycle pr_addr", pr_addr, 64'h4004);
      next_edge();
      ex_br = 1'b0;
      #2;
      chk("bypass pr_taken", 64'(pr_taken), 64'd1);
      chk("bypass pr_addr", pr_addr, 64'h4010);
      rst = 1'b1;
      #1;
      chk("rst_in_bypass pr_taken", 64'(pr_taken), 64'd0);
      chk("rst_in_bypass pr_addr", pr_addr, 64'h4004);
      chk("rst_in_bypass br_cnt", 64'(br_cnt), 64'd0);
      rst = 1'b0;
      next_edge();
      #2;
      chk("dropped_write pr_taken", 64'(pr_taken), 64'd0);
      next_edge();

      // Statistics saturation
      pulse_rst();
      ex_br = 1'b1; ex_miss = 1'b1; ex_pc = 64'h5000; ex_taken = 1'b0;
      for (int i = 0; i < CMAX - 1; i++) next_edge();
      chk("sat_pre br_cnt", 64'(br_cnt), 64'(CMAX - 1));
      chk("sat_pre miss_cnt", 64'(miss_cnt), 64'(CMAX - 1));
      for (int i = 0; i < 3; i++) begin
         next_edge();
         chk($sformatf("sat%0d br_cnt", i), 64'(br_cnt), 64'(CMAX));
         chk($sformatf("sat%0d miss_cnt", i), 64'(miss_cnt), 64'(CMAX));
      end
      ex_br = 1'b0;
      next_edge();
      chk("miss_ignored br_cnt", 64'(br_cnt), 64'(CMAX));
      chk("miss_ignored miss_cnt", 64'(miss_cnt), 64'(CMAX));

      // Random traffic against the architectural model
      pulse_rst();
      model_reset();
      for (int c = 0; c < 600; c++) begin
         if_pc = {$urandom(), 22'($urandom()), 3'($urandom()), 2'($urandom_range(0, 1) * 2)};
         if ($urandom_range(0, 1)) begin
            if_ir = {$urandom()};
            if_ir[6:0] = 7'b1100011;
         end else begin
            if_ir = $urandom();
         end
         ex_br = ($urandom_range(0, 9) < 6);
         epc_al = {$urandom(), 22'($urandom()), 3'($urandom()), 2'b00};
         ex_pc = epc_al;
         ex_taken = $urandom_range(0, 1);
         ex_miss = $urandom_range(0, 1);
         #2;
         exp_tk = (if_ir[6:0] == 7'b1100011) && (mctr[pc_idx(if_pc)] >= 2);
         chk("rnd pr_taken", 64'(pr_taken), 64'(exp_tk));
         chk("rnd pr_addr", pr_addr, model_addr(if_pc, if_ir, exp_tk));
         chk("rnd br_cnt", 64'(br_cnt), 64'(mbr));
         chk("rnd miss_cnt", 64'(miss_cnt), 64'(mmiss));
         if ($urandom_range(0, 99) == 0) begin
            #1;
            pulse_rst();
            model_reset();
         end
         next_edge();
         if (ex_br) begin
            int k;
            k = pc_idx(ex_pc);
            mctr[k] = ex_taken ? ((mctr[k] < 3) ? mctr[k] + 1 : 3)
                               : ((mctr[k] > 0) ? mctr[k] - 1 : 0);
            if (mbr < CMAX) mbr++;
            if (ex_miss && mmiss < CMAX) mmiss++;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
